// File: rtl/cache_arb_types.sv
// Shared types for the I/D cache-to-memory line arbiter.
// Optional build macro: CACHE_ARB_RR_EN (round-robin arbitration in place of
// dcache priority with the icache starvation guard).
package cache_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // True while a memory transaction is being driven for either requester.
  function automatic logic is_serving(input arb_state_t s);
    return (s == SERVE_I) || (s == SERVE_D);
  endfunction

endpackage

// File: rtl/cache_arb_starve_ctr.sv
// Saturating count of consecutive dcache grants made while the icache waits.
// Only used when CACHE_ARB_RR_EN is undefined.
module cache_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the icache and dcache miss
// paths. One transaction at a time; address, write data and op are latched at
// grant so requester inputs are ignored during service.
// Optional build macro: CACHE_ARB_RR_EN -- simultaneous requests alternate
// instead of dcache priority with the icache starvation guard.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  grant_t            r_gnt;
  op_t               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_d_req;
  logic w_prefer_i;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_serving;

  assign w_d_req   = d_read | d_write;
  assign w_serving = is_serving(r_state);

`ifdef CACHE_ARB_RR_EN
  grant_t r_last_grant;

  assign w_prefer_i = (r_last_grant == GNT_D);

  // Remember the most recent winner so a tie goes to the other requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GNT_D;
    end else if (w_gnt_i) begin
      r_last_grant <= GNT_I;
    end else if (w_gnt_d) begin
      r_last_grant <= GNT_D;
    end
  end
`else
  logic w_at_limit;

  cache_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_gnt_d & i_read),
    .i_clr     (w_gnt_i),
    .o_at_limit(w_at_limit)
  );

  assign w_prefer_i = w_at_limit;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and grant decision; grants happen only from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_gnt_i      = 1'b0;
    w_gnt_d      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_read && (!w_d_req || w_prefer_i)) begin
          w_gnt_i      = 1'b1;
          w_next_state = SERVE_I;
        end else if (w_d_req) begin
          w_gnt_d      = 1'b1;
          w_next_state = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Capture the winner's transaction; write takes precedence if both d strobes are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt   <= GNT_D;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt_i) begin
      r_gnt  <= GNT_I;
      r_op   <= OP_RD;
      r_addr <= i_addr;
    end else if (w_gnt_d) begin
      r_gnt   <= GNT_D;
      r_op    <= d_write ? OP_WR : OP_RD;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end
  end

  // Fill data is taken on the mem_resp edge and held until that requester's next fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_serving && mem_resp && (r_op == OP_RD)) begin
      if (r_gnt == GNT_I) begin
        r_i_rdata <= mem_rdata;
      end else begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_read  = w_serving && (r_op == OP_RD);
  assign mem_write = w_serving && (r_op == OP_WR);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_resp    = (r_state == DONE) && (r_gnt == GNT_I);
  assign d_resp    = (r_state == DONE) && (r_gnt == GNT_D);

`ifndef SYNTHESIS
  a_d_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, reset and arbitration-order
// sequences, then randomized requesters/memory against a transaction model.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_arbiter #(
    .ADDR_W      (AW),
    .LINE_W      (LW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp (mem_resp)
  );

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da;
    logic        mr;
    logic        e_mr, e_mw, e_ir, e_dr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tv[13];

  function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                              input logic [31:0] ia, input logic [31:0] da, input logic mr,
                              input logic emr, input logic emw, input logic eir, input logic edr,
                              input logic [31:0] ea);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.mr = mr;
    v.e_mr = emr; v.e_mw = emw; v.e_ir = eir; v.e_dr = edr; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_read"}, mem_read, 0);
    chk({nm, "_mem_write"}, mem_write, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_i_rdata"}, i_rdata, 0);
    chk({nm, "_d_rdata"}, d_rdata, 0);
    chk({nm, "_i_resp"}, i_resp, 0);
    chk({nm, "_d_resp"}, d_resp, 0);
  endtask

  initial begin
    logic [LW-1:0] la5;
    logic [LW-1:0] wd;
    bit            exp_d[10];
    int            g;
    logic          prev_mr;
    // reference model state
    bit            m_busy, m_who_d, m_wr, m_done, m_done_d, m_last_d;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_irdata, m_drdata;
    int            m_starve, mem_wait;
    bit            i_pend, d_pend, d_wr_op, i_rel, d_rel, pick_i, d_req, prefer_i;

    la5 = {32{8'hA5}};
    wd  = {8{32'h1234_5678}};

    tv[0]  = mk(1, 0, 0, 'h100, 0, 0, 1, 0, 0, 0, 'h100);
    tv[1]  = mk(1, 0, 0, 'h100, 0, 0, 1, 0, 0, 0, 'h100);
    tv[2]  = mk(1, 0, 0, 'h100, 0, 0, 1, 0, 0, 0, 'h100);
    tv[3]  = mk(1, 0, 0, 'h100, 0, 1, 0, 0, 1, 0, 0);
    tv[4]  = mk(1, 0, 0, 'h100, 0, 0, 0, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[6]  = mk(0, 0, 1, 0, 'h2000, 0, 0, 1, 0, 0, 'h2000);
    tv[7]  = mk(0, 0, 1, 0, 'h3000, 0, 0, 1, 0, 0, 'h2000);
    tv[8]  = mk(0, 0, 1, 0, 'h3000, 1, 0, 0, 0, 1, 0);
    tv[9]  = mk(0, 0, 1, 0, 'h3000, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- reset state ----
    do_reset();
    chk_all_zero("reset");

    // ---- directed table: lone icache fill, stale request, dcache write-back ----
    mem_rdata = la5;
    d_wdata   = wd;
    for (int i = 0; i < 13; i++) begin
      i_read = tv[i].ir; d_read = tv[i].dr; d_write = tv[i].dw;
      i_addr = tv[i].ia; d_addr = tv[i].da; mem_resp = tv[i].mr;
      tick();
      chk($sformatf("v%0d_mem_read", i), mem_read, tv[i].e_mr);
      chk($sformatf("v%0d_mem_write", i), mem_write, tv[i].e_mw);
      chk($sformatf("v%0d_i_resp", i), i_resp, tv[i].e_ir);
      chk($sformatf("v%0d_d_resp", i), d_resp, tv[i].e_dr);
      if (tv[i].e_mr || tv[i].e_mw) chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].e_addr);
      if (tv[i].e_mw) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, wd);
    end
    chk("fill_i_rdata", i_rdata, la5);
    chk("wb_d_rdata_kept", d_rdata, 0);

    // ---- asynchronous reset in the middle of a dcache write ----
    d_write = 1'b1; d_addr = 'h4000; d_wdata = wd; mem_resp = 1'b0;
    tick();
    chk("pre_rst_mem_write", mem_write, 1);
    tick();
    chk("pre_rst_mem_write2", mem_write, 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    d_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("post_rst_idle_write", mem_write, 0);
    chk("post_rst_idle_read", mem_read, 0);

    // ---- both requesting continuously: grant order ----
    do_reset();
`ifdef CACHE_ARB_RR_EN
    for (int i = 0; i < 10; i++) exp_d[i] = (i % 2) == 1;
`else
    for (int i = 0; i < 10; i++) exp_d[i] = (i % 5) != 4;
`endif
    i_read = 1'b1; i_addr = 'h100; d_read = 1'b1; d_addr = 'h200; mem_resp = 1'b1;
    g = 0;
    prev_mr = 1'b0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      tick();
      if (mem_read && !prev_mr) begin
        chk($sformatf("grant_order_%0d", g), mem_addr, exp_d[g] ? 32'h200 : 32'h100);
        g++;
      end
      prev_mr = mem_read;
    end
    if (g < 10) begin
      n_vec++;
      n_err++;
      $display("FAIL grant_order_timeout: got %0d grants expected 10", g);
    end

    // ---- randomized traffic against transaction model ----
    do_reset();
    m_busy = 0; m_who_d = 0; m_wr = 0; m_done = 0; m_done_d = 0; m_last_d = 1;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_starve = 0; mem_wait = 0;
    i_pend = 0; d_pend = 0; d_wr_op = 0; i_rel = 0; d_rel = 0;
    for (int c = 0; c < 500; c++) begin
      chk("rnd_mem_read", mem_read, m_busy && !m_wr);
      chk("rnd_mem_write", mem_write, m_busy && m_wr);
      chk("rnd_i_resp", i_resp, m_done && !m_done_d);
      chk("rnd_d_resp", d_resp, m_done && m_done_d);
      chk("rnd_i_rdata", i_rdata, m_irdata);
      chk("rnd_d_rdata", d_rdata, m_drdata);
      if (m_busy) chk("rnd_mem_addr", mem_addr, m_addr);
      if (m_busy && m_wr) chk("rnd_mem_wdata", mem_wdata, m_wdata);

      // requesters hold through their response cycle, then drop
      if (i_rel) begin
        i_pend = 0; i_rel = 0;
      end else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1;
      end
      if (m_done && !m_done_d) i_rel = 1;
      if (d_rel) begin
        d_pend = 0; d_rel = 0;
      end else if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wr_op = $urandom_range(0, 1) == 1;
      end
      if (m_done && m_done_d) d_rel = 1;

      i_read  = i_pend;
      d_read  = d_pend && !d_wr_op;
      d_write = d_pend && d_wr_op;
      i_addr  = $urandom & 32'hFFFF_FFE0;
      d_addr  = $urandom & 32'hFFFF_FFE0;
      d_wdata = rnd_line();
      mem_rdata = rnd_line();
      if (m_busy) begin
        if (mem_wait == 0) mem_resp = 1'b1;
        else begin
          mem_resp = 1'b0;
          mem_wait--;
        end
      end else begin
        mem_resp = ($urandom_range(0, 7) == 0);
      end

      // model: what the coming edge does to the transaction
      d_req = d_read || d_write;
      if (m_busy) begin
        if (mem_resp) begin
          if (!m_wr) begin
            if (m_who_d) m_drdata = mem_rdata;
            else m_irdata = mem_rdata;
          end
          m_busy = 0; m_done = 1; m_done_d = m_who_d;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (i_read || d_req) begin
`ifdef CACHE_ARB_RR_EN
        prefer_i = m_last_d;
`else
        prefer_i = (m_starve == SL);
`endif
        pick_i = i_read && (!d_req || prefer_i);
        m_busy = 1;
        m_who_d = !pick_i;
        m_last_d = !pick_i;
        mem_wait = $urandom_range(0, 3);
        if (pick_i) begin
          m_wr = 0; m_addr = i_addr; m_starve = 0;
        end else begin
          m_wr = d_write; m_addr = d_addr;
          m_wdata = d_wdata;
          if (i_read && m_starve < SL) m_starve++;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
